x_ibuf_sync: RTL and testbench



---
 rtl/x_io_pkg.sv | 37 +++
 rtl/x_ibuf.sv | 54 +++++
 rtl/x_ibuf_sync.sv | 160 ++++++++++++++++
 tb/tb_x_ibuf_sync.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/x_io_pkg.sv
// -----------------------------------------------------------------------------
// x_io_pkg
// Shared definitions for the pad-boundary I/O wrappers: legal FPGA series and
// pad physics names, a constant clog2 helper for sizing counters, and the
// state type of the input glitch-filter FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package x_io_pkg;

    localparam string SERIES_7    = "7SERIRE";
    localparam string SERIES_5    = "5SERIRE";
    localparam string SERIES_4    = "4SERIRE";

    localparam string MODE_DIFF   = "DIFF";
    localparam string MODE_SINGLE = "SINGLE";

    // IDLE: candidate word equals the accepted word.
    // SETTLE: a different word was seen and is waiting to prove itself stable.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } filt_state_e;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/x_ibuf.sv
// -----------------------------------------------------------------------------
// x_ibuf
// Per-bit input buffer selection. Behavioural stand-in for IBUF (single-ended)
// or IBUFDS (differential) with the attribute set chosen by FPGA_SERIES and
// PHYSICS_MODE. Purely combinational.
// Ports:
//   pin_p    in  DATA_WIDTH  P leg, or the single-ended pad
//   pin_n    in  DATA_WIDTH  N leg (ignored in SINGLE)
//   data_in  out DATA_WIDTH  buffered pad word
// -----------------------------------------------------------------------------
module x_ibuf
    import x_io_pkg::*;
#(
    parameter int    DATA_WIDTH   = 16,
    parameter string FPGA_SERIES  = SERIES_7,
    parameter string PHYSICS_MODE = MODE_DIFF,
    parameter string IOSTANDARD   = "DEFAULT",
    parameter string DIFF_TERM    = "FALSE",
    parameter string IBUF_LOW_PWR = "TRUE"
) (
    input  logic [DATA_WIDTH-1:0] pin_p,
    input  logic [DATA_WIDTH-1:0] pin_n,
    output logic [DATA_WIDTH-1:0] data_in
);

    localparam bit SERIES_OK = (FPGA_SERIES == SERIES_7) || (FPGA_SERIES == SERIES_5) ||
                               (FPGA_SERIES == SERIES_4);
    localparam bit IS_DIFF   = (PHYSICS_MODE == MODE_DIFF);
    localparam bit MODE_OK   = IS_DIFF || (PHYSICS_MODE == MODE_SINGLE);
    localparam bit ATTR_OK   = (IOSTANDARD != "") &&
                               ((DIFF_TERM == "TRUE") || (DIFF_TERM == "FALSE")) &&
                               ((IBUF_LOW_PWR == "TRUE") || (IBUF_LOW_PWR == "FALSE"));

    if (!(SERIES_OK && MODE_OK && ATTR_OK)) begin : g_bad_cfg
        // An unsupported attribute set ties the bus off so it is obvious at once.
        assign data_in = '0;
        logic unused_pins;
        assign unused_pins = ^{pin_p, pin_n};
    end else if (IS_DIFF) begin : g_diff
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
            // IBUFDS: high only when P is high and N is low; an invalid
            // (equal-leg) pair resolves to 0 instead of holding state.
            assign data_in[i] = pin_p[i] & ~pin_n[i];
        end
    end else begin : g_single
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
            assign data_in[i] = pin_p[i];
        end
        // Lint sink only: the N leg drives nothing in single-ended mode.
        logic unused_pin_n;
        assign unused_pin_n = ^pin_n;
    end

endmodule

// File: rtl/x_ibuf_sync.sv
// -----------------------------------------------------------------------------
// x_ibuf_sync
// Pad input path into the fabric clock domain: input buffer, SYNC_STAGES-deep
// synchronizer, glitch filter (a word must be seen FILTER_CYCLES+1 consecutive
// clocks), and a valid/ready change-event register with sticky overflow.
// Ports:
//   clk        in   1           fabric clock
//   rst_n      in   1           asynchronous active-low reset
//   pin_p      in   DATA_WIDTH  P leg or single-ended pad
//   pin_n      in   DATA_WIDTH  N leg (ignored in SINGLE)
//   stable_q   out  DATA_WIDTH  last accepted word
//   out_data   out  DATA_WIDTH  word captured at the last change event
//   out_valid  out  1           change event pending
//   out_ready  in   1           consumer accepts when out_valid && out_ready
//   ovf        out  1           sticky: event overwrote an unaccepted one
//   ovf_clr    in   1           synchronous clear of ovf (set wins)
// -----------------------------------------------------------------------------
module x_ibuf_sync
    import x_io_pkg::*;
#(
    parameter int    DATA_WIDTH    = 16,
    parameter string FPGA_SERIES   = SERIES_7,
    parameter string PHYSICS_MODE  = MODE_DIFF,
    parameter string IOSTANDARD    = "DEFAULT",
    parameter string DIFF_TERM     = "FALSE",
    parameter string IBUF_LOW_PWR  = "TRUE",
    parameter int    SYNC_STAGES   = 2,
    parameter int    FILTER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pin_p,
    input  logic [DATA_WIDTH-1:0] pin_n,
    output logic [DATA_WIDTH-1:0] stable_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int             CNT_W   = clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic [DATA_WIDTH-1:0] pad_word;

    x_ibuf #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FPGA_SERIES (FPGA_SERIES),
        .PHYSICS_MODE(PHYSICS_MODE),
        .IOSTANDARD  (IOSTANDARD),
        .DIFF_TERM   (DIFF_TERM),
        .IBUF_LOW_PWR(IBUF_LOW_PWR)
    ) u_ibuf (
        .pin_p  (pin_p),
        .pin_n  (pin_n),
        .data_in(pad_word)
    );

    // Synchronizer: plain flop chain, nothing between stages.
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is a few flops, not a RAM, so every stage is reset.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes its predecessor's old value.
            sync_q[0] <= pad_word;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_word = sync_q[SYNC_STAGES-1];

    // Filter and acceptance FSM
    logic [DATA_WIDTH-1:0] cand_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    filt_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] stable_word_q, stable_word_d;
    logic                  event_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        cnt_d         = cnt_q;
        state_d       = state_q;
        stable_word_d = stable_word_q;
        event_d       = 1'b0;

        // Any bit toggle restarts the count; saturate once the window is full.
        if (sync_word != cand_q) cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (sync_word != stable_word_q) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (sync_word == cand_q && cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    // A glitch that returned to the accepted word raises nothing.
                    if (cand_q != stable_word_q) begin
                        stable_word_d = cand_q;
                        event_d       = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Event / handshake register
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (ovf_clr) ovf_d = 1'b0;

        // A new event always lands; it only overflows if the old one was not
        // being accepted this same cycle. Set overrides clear.
        if (event_d) begin
            out_data_d  = stable_word_d;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q        <= '0;
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            stable_word_q <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            cand_q        <= sync_word;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            stable_word_q <= stable_word_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            ovf_q         <= ovf_d;
        end
    end

    assign stable_q  = stable_word_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_x_ibuf_sync.sv
// -----------------------------------------------------------------------------
// tb_x_ibuf_sync
// Two instances of x_ibuf_sync (SINGLE and DIFF) share stimulus. A reference
// model tracks the pad word as the fabric sees it SYNC clocks later, accepts a
// word once it has been seen FC+1 consecutive clocks and differs from the
// accepted word, and queues the expected change events. A negedge monitor
// compares both instances against the model and retires accepted events.
// -----------------------------------------------------------------------------
module tb_x_ibuf_sync;

    localparam int DW   = 16;
    localparam int SYNC = 2;
    localparam int FC   = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [DW-1:0] pin_p     = '0;
    logic [DW-1:0] pin_n_junk = '0;
    logic [DW-1:0] pin_n_diff;
    logic          out_ready = 1'b0;
    logic          ovf_clr   = 1'b0;

    assign pin_n_diff = ~pin_p;

    logic [DW-1:0] s_stable, s_data, d_stable, d_data;
    logic          s_valid, s_ovf, d_valid, d_ovf;

    always #5 clk = ~clk;

    x_ibuf_sync #(
        .DATA_WIDTH(DW), .PHYSICS_MODE("SINGLE"), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC)
    ) u_dut_single (
        .clk(clk), .rst_n(rst_n), .pin_p(pin_p), .pin_n(pin_n_junk),
        .stable_q(s_stable), .out_data(s_data), .out_valid(s_valid),
        .out_ready(out_ready), .ovf(s_ovf), .ovf_clr(ovf_clr)
    );

    x_ibuf_sync #(
        .DATA_WIDTH(DW), .PHYSICS_MODE("DIFF"), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FC)
    ) u_dut_diff (
        .clk(clk), .rst_n(rst_n), .pin_p(pin_p), .pin_n(pin_n_diff),
        .stable_q(d_stable), .out_data(d_data), .out_valid(d_valid),
        .out_ready(out_ready), .ovf(d_ovf), .ovf_clr(ovf_clr)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] pad_hist[$];   // pad samples not yet visible to the fabric
    logic [DW-1:0] last_seen;
    logic [DW-1:0] m_seen;
    logic [DW-1:0] m_stable;
    int            run_len;
    logic [DW-1:0] exp_q[$];      // expected pending event (at most one)
    logic          m_ovf;

    task automatic model_reset();
        pad_hist.delete();
        for (int i = 0; i < SYNC; i++) pad_hist.push_back('0);
        last_seen = '0;
        run_len   = FC + 1;
        m_stable  = '0;
        exp_q.delete();
        m_ovf     = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_seen = pad_hist.pop_front();
            pad_hist.push_back(pin_p);
            if (m_seen == last_seen) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_len = 1;
            end
            last_seen = m_seen;
            if (ovf_clr) m_ovf = 1'b0;
            if (run_len >= FC + 1 && m_seen != m_stable) begin
                m_stable = m_seen;
                // Still pending here means the consumer did not take it.
                if (exp_q.size() != 0) begin
                    exp_q.delete();
                    m_ovf = 1'b1;
                end
                exp_q.push_back(m_seen);
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic check_dut(input string tag, input logic [DW-1:0] st, input logic [DW-1:0] dat,
                             input logic v, input logic o);
        check({tag, " out_valid"}, 32'(v), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, " out_data"}, 32'(dat), 32'(exp_q[0]));
        check({tag, " stable_q"}, 32'(st), 32'(m_stable));
        check({tag, " ovf"}, 32'(o), 32'(m_ovf));
    endtask

    always @(negedge clk) begin
        check_dut("single", s_stable, s_data, s_valid, s_ovf);
        check_dut("diff", d_stable, d_data, d_valid, d_ovf);
        if (rst_n && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept_one();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int hold;

        // 1: reset, pins at 0
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("idle stable_q", 32'(s_stable), 32'h0);
        check("idle out_valid", 32'(s_valid), 32'h0);

        // 2: A5A5 held; latency from pad change to out_valid
        pin_p = 16'hA5A5;
        lat = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            tick(1);
            if (s_valid) lat = c;
        end
        check("a5a5 latency", 32'(lat), 32'd7);
        check("a5a5 out_data", 32'(s_data), 32'hA5A5);
        check("a5a5 stable_q", 32'(s_stable), 32'hA5A5);
        accept_one();

        // 3: back to 0, then a 2-clock glitch
        pin_p = 16'h0000;
        tick(12);
        accept_one();
        pin_p = 16'h0001;
        tick(2);
        pin_p = 16'h0000;
        tick(15);
        check("glitch stable_q", 32'(s_stable), 32'h0);
        check("glitch out_valid", 32'(s_valid), 32'h0);

        // 4: two changes without acceptance -> overwrite and overflow
        pin_p = 16'h1111;
        tick(12);
        pin_p = 16'h2222;
        tick(12);
        check("ovf out_data", 32'(s_data), 32'h2222);
        check("ovf set single", 32'(s_ovf), 32'h1);
        check("ovf set diff", 32'(d_ovf), 32'h1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf cleared", 32'(s_ovf), 32'h0);
        accept_one();

        // 5: accept in the same cycle as a new event
        pin_p = 16'h3333;
        tick(12);
        pin_p = 16'h4444;
        tick(6);
        out_ready = 1'b1;
        tick(1);
        check("same-cycle out_valid", 32'(s_valid), 32'h1);
        check("same-cycle out_data", 32'(s_data), 32'h4444);
        check("same-cycle ovf", 32'(s_ovf), 32'h0);
        tick(1);
        out_ready = 1'b0;

        // 6: differential word, then reset in the middle of settling
        pin_p = 16'h00FF;
        tick(12);
        check("diff out_data", 32'(d_data), 32'h00FF);
        check("diff stable_q", 32'(d_stable), 32'h00FF);
        accept_one();
        pin_p = 16'h1234;
        tick(5);
        rst_n = 1'b0;
        #1;
        check("rst stable_q", 32'(s_stable), 32'h0);
        check("rst out_data", 32'(s_data), 32'h0);
        check("rst out_valid", 32'(s_valid), 32'h0);
        check("rst ovf", 32'(s_ovf), 32'h0);
        check("rst diff stable_q", 32'(d_stable), 32'h0);
        check("rst diff out_data", 32'(d_data), 32'h0);
        check("rst diff out_valid", 32'(d_valid), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(12);
        check("post-rst stable_q", 32'(s_stable), 32'h1234);
        check("post-rst out_valid", 32'(s_valid), 32'h1);
        accept_one();

        // 7: randomized pads, consumer and clears
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 3))
                    0: pin_p = 16'($urandom);
                    1: pin_p = pin_p ^ (16'h1 << $urandom_range(0, 15));
                    default: ;
                endcase
                hold = $urandom_range(1, 9);
            end
            hold--;
            out_ready  = 1'($urandom_range(0, 1));
            ovf_clr    = ($urandom_range(0, 15) == 0);
            pin_n_junk = 16'($urandom);
            tick(1);
        end

        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
